wipe_sequencer: RTL
===================

Name: wipe_sequencer

Overview:
Parametrised screen-wipe engine that emits a sequence of line endpoints (x0,y0,x1,y1) to a downstream line drawer. It sweeps the full frame row-by-row or column-by-column with a configurable stride, and steps with a valid/ready + done handshake so the drawer controls pacing. It sits between the board-level key/control logic and line_drawer. It replaces the fixed single-mode wipe with a generalised width/height/stride/mode engine.

Parameters:
WIDTH, 640, frame width in pixels
HEIGHT, 480, frame height in pixels
XW, 10, x coordinate width (>= clog2(WIDTH))
YW, 9, y coordinate width (>= clog2(HEIGHT))
STEP, 1, stride between successive lines (1..min(WIDTH,HEIGHT))

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  level; sampled in IDLE only, begins a wipe
mode  in  2  0=ROW (horizontal lines, y steps), 1=COL (vertical lines, x steps), 2/3=ROW
line_valid  out  1  endpoint set valid
line_ready  in  1  drawer accepts endpoints
line_done  in  1  drawer finished current line (1-cycle pulse)
x0  out  XW  start x
y0  out  YW  start y
x1  out  XW  end x
y1  out  YW  end y
busy  out  1  high outside IDLE
done  out  1  1-cycle pulse at wipe completion

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, idx=0, x0=y0=x1=y1=0, line_valid=0, busy=0, done=0. Applies mid-wipe; no further lines issued.
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE: if start==1, latch mode into mode_q, idx<=0, go ISSUE. busy goes high the cycle after start is sampled.
- ISSUE: line_valid=1. Coordinates are registered and stable while valid. ROW: x0=0, x1=WIDTH-1, y0=y1=idx. COL: y0=0, y1=HEIGHT-1, x0=x1=idx. On line_valid&&line_ready -> WAIT (line_valid drops next cycle).
- WAIT: hold coordinates; on line_done -> NEXT. line_done outside WAIT is ignored.
- NEXT: last = (mode_q==COL) ? WIDTH-1 : HEIGHT-1. If idx+STEP > last -> FIN, else idx<=idx+STEP, -> ISSUE. Comparison is done at max(XW,YW)+1 bits; no wrap.
- FIN: done=1 for exactly one cycle, -> IDLE. busy=0 in the IDLE cycle after FIN.
- start while busy: ignored. mode changes mid-wipe: ignored (mode_q used).
- Lines per wipe = floor(last/STEP)+1. Minimum 1 (STEP>last issues line 0 only).
- Simultaneous line_ready in the same cycle valid rises: accepted that cycle. Handshake latency from ISSUE to WAIT is 1 cycle.

Optional Feature:
WIPE_REVERSE_EN. When defined, add input reverse (1 bit), latched with mode at start. reverse=1: idx starts at last - (last mod STEP) and decrements by STEP; FIN when idx < STEP. Line count is unchanged. When undefined: no reverse port; ascending sweep only.

Decomposition:
- Package wipe_pkg: mode enum (MODE_ROW=0, MODE_COL=1), state enum, and a DIM_W = max(XW,YW)+1 helper constant.
- Optional sub-module wipe_index_counter: holds idx, last and the step/terminal compare; the FSM stays in wipe_sequencer.

Test Plan:
- Reset then start=1, mode=0, STEP=1, line_ready=1, line_done 2 cycles after each accept -> 480 lines y=0..479, x0=0, x1=639, then one done pulse and busy=0.
- mode=1, STEP=80 -> 8 lines x=0,80,...,560, y0=0, y1=479, then done.
- line_ready held 0 for 10 cycles in ISSUE -> line_valid and coordinates stable throughout; accept on the first ready cycle.
- start pulsed again and mode toggled mid-wipe -> no restart, sequence unchanged.
- reset=0 during WAIT at line 5 -> next cycle all outputs 0, state IDLE; a spurious line_done afterwards has no effect.
- WIPE_REVERSE_EN defined, mode=0, STEP=100, reverse=1 -> y=400,300,200,100,0, then done.

Source files
------------

// File: rtl/wipe_pkg.sv
// Shared types and width helpers for the screen-wipe sequencer.
package wipe_pkg;

    localparam int unsigned XW_DEF = 10;
    localparam int unsigned YW_DEF = 9;

    typedef enum logic [1:0] {
        MODE_ROW = 2'd0,
        MODE_COL = 2'd1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // One bit wider than the widest coordinate so idx+STEP never wraps
    function automatic int unsigned dim_w(input int unsigned xw, input int unsigned yw);
        return ((xw > yw) ? xw : yw) + 1;
    endfunction

    localparam int unsigned DIM_W = dim_w(XW_DEF, YW_DEF);

endpackage

// File: rtl/wipe_index_counter.sv
// Line index counter for the wipe sequencer: holds idx, the latched sweep
// direction/orientation, and the stride/terminal compare.
module wipe_index_counter
    import wipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned STEP   = 1,
    parameter int unsigned DW     = DIM_W
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_col,
    input  logic          i_rev,
    input  logic          i_adv,
    output logic [DW-1:0] o_idx_nxt_c,
    output logic          o_col_nxt_c,
    output logic          o_term_c
);

    localparam logic [DW-1:0] LAST_ROW = DW'(HEIGHT - 1);
    localparam logic [DW-1:0] LAST_COL = DW'(WIDTH - 1);
    localparam logic [DW-1:0] TOP_ROW  = DW'((HEIGHT - 1) - ((HEIGHT - 1) % STEP));
    localparam logic [DW-1:0] TOP_COL  = DW'((WIDTH - 1) - ((WIDTH - 1) % STEP));
    localparam logic [DW-1:0] STEP_D   = DW'(STEP);

    logic [DW-1:0] r_idx;
    logic          r_col;
    logic          r_rev;
    logic [DW-1:0] w_last;
    logic [DW-1:0] w_sum;
    logic [DW-1:0] w_idx_nxt;
    logic          w_col_nxt;
    logic          w_rev_nxt;

    // Terminal test: is the line just drawn the last one of this sweep
    always_comb begin
        w_last   = r_col ? LAST_COL : LAST_ROW;
        w_sum    = r_idx + STEP_D;
        o_term_c = r_rev ? (r_idx < STEP_D) : (w_sum > w_last);
    end

    // Next index and latched sweep attributes
    always_comb begin
        w_idx_nxt = r_idx;
        w_col_nxt = r_col;
        w_rev_nxt = r_rev;
        if (i_load) begin
            w_col_nxt = i_col;
            w_rev_nxt = i_rev;
            w_idx_nxt = i_rev ? (i_col ? TOP_COL : TOP_ROW) : '0;
        end else if (i_adv) begin
            w_idx_nxt = r_rev ? (r_idx - STEP_D) : w_sum;
        end
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_col <= 1'b0;
            r_rev <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;
            r_col <= w_col_nxt;
            r_rev <= w_rev_nxt;
        end
    end

    assign o_idx_nxt_c = w_idx_nxt;
    assign o_col_nxt_c = w_col_nxt;

endmodule

// File: rtl/wipe_sequencer.sv
// Screen-wipe engine: emits full-frame row or column line endpoints to a
// line drawer with valid/ready + done pacing.
// Optional macro WIPE_REVERSE_EN adds a 'reverse' input for descending sweeps.
module wipe_sequencer
    import wipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned XW     = 10,
    parameter int unsigned YW     = 9,
    parameter int unsigned STEP   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
`ifdef WIPE_REVERSE_EN
    input  logic          reverse,
`endif
    output logic          line_valid,
    input  logic          line_ready,
    input  logic          line_done,
    output logic [XW-1:0] x0,
    output logic [YW-1:0] y0,
    output logic [XW-1:0] x1,
    output logic [YW-1:0] y1,
    output logic          busy,
    output logic          done
);

    localparam int unsigned DW = dim_w(XW, YW);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_load;
    logic          w_adv;
    logic          w_term;
    logic          w_rev;
    logic          w_col_nxt;
    logic [DW-1:0] w_idx_nxt;

    logic          r_line_valid, w_line_valid_nxt;
    logic          r_busy,       w_busy_nxt;
    logic          r_done,       w_done_nxt;
    logic [XW-1:0] r_x0,         w_x0_nxt;
    logic [YW-1:0] r_y0,         w_y0_nxt;
    logic [XW-1:0] r_x1,         w_x1_nxt;
    logic [YW-1:0] r_y1,         w_y1_nxt;

`ifdef WIPE_REVERSE_EN
    assign w_rev = reverse;
`else
    assign w_rev = 1'b0;
`endif

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_adv  = (r_state == ST_NEXT) && !w_term;

    wipe_index_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .STEP   (STEP),
        .DW     (DW)
    ) u_idx (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_load      (w_load),
        .i_col       (mode == 2'(MODE_COL)),
        .i_rev       (w_rev),
        .i_adv       (w_adv),
        .o_idx_nxt_c (w_idx_nxt),
        .o_col_nxt_c (w_col_nxt),
        .o_term_c    (w_term)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)                     w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (r_line_valid && line_ready) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (line_done)                 w_state_nxt = ST_NEXT;
            ST_NEXT:  w_state_nxt = w_term ? ST_FIN : ST_ISSUE;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output next values, aligned to the state being entered
    always_comb begin
        w_line_valid_nxt = (w_state_nxt == ST_ISSUE);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_done_nxt       = (w_state_nxt == ST_FIN);
        w_x0_nxt         = r_x0;
        w_y0_nxt         = r_y0;
        w_x1_nxt         = r_x1;
        w_y1_nxt         = r_y1;
        if (w_state_nxt == ST_ISSUE) begin
            if (w_col_nxt) begin
                w_x0_nxt = XW'(w_idx_nxt);
                w_x1_nxt = XW'(w_idx_nxt);
                w_y0_nxt = '0;
                w_y1_nxt = YW'(HEIGHT - 1);
            end else begin
                w_x0_nxt = '0;
                w_x1_nxt = XW'(WIDTH - 1);
                w_y0_nxt = YW'(w_idx_nxt);
                w_y1_nxt = YW'(w_idx_nxt);
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_line_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_x1         <= '0;
            r_y1         <= '0;
        end else begin
            r_line_valid <= w_line_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_x0         <= w_x0_nxt;
            r_y0         <= w_y0_nxt;
            r_x1         <= w_x1_nxt;
            r_y1         <= w_y1_nxt;
        end
    end

    assign line_valid = r_line_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign x0         = r_x0;
    assign y0         = r_y0;
    assign x1         = r_x1;
    assign y1         = r_y1;

endmodule
